// File: rtl/uart_pkg.sv
// Shared constants, FSM encoding and helpers for the FIFO-backed UART transmitter.
// Optional clear-to-send gating is enabled with UART_TX_CTS_EN.
package uart_pkg;

    localparam logic [1:0] PAR_SPACE = 2'b00;
    localparam logic [1:0] PAR_EVEN  = 2'b01;
    localparam logic [1:0] PAR_ODD   = 2'b10;
    localparam logic [1:0] PAR_MARK  = 2'b11;

    localparam int DATA_OFS = 5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_STOP2
    } state_t;

    function automatic logic [7:0] data_mask(input logic [1:0] bits);
        return 8'hFF >> (2'd3 - bits);
    endfunction

    function automatic logic parity_bit(input logic [1:0] mode, input logic [7:0] d);
        unique case (mode)
            PAR_EVEN: return ^d;
            PAR_ODD:  return ~^d;
            PAR_MARK: return 1'b1;
            default:  return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/uart_fifo_transmitter_if.sv
// Host push interface of the UART transmitter: word, push strobe and FIFO status.
// Shared by all builds, with or without UART_TX_CTS_EN.
interface uart_fifo_transmitter_if #(
    parameter int LVL_W = 3
);
    logic [7:0]       data;
    logic             push;
    logic             full;
    logic [LVL_W-1:0] level;
    logic             overflow;
    logic             ready;

    modport master (
        output data, push,
        input  full, level, overflow, ready
    );

    modport slave (
        input  data, push,
        output full, level, overflow, ready
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// Circular TX word buffer; pointers carry an extra wrap bit for full/empty decode.
// Unaffected by UART_TX_CTS_EN.
module uart_tx_fifo #(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  logic        pop,
    input  logic [7:0]  din,
    output logic [7:0]  dout,
    output logic        full,
    output logic        empty,
    output logic [AW:0] level
);
    localparam logic [AW:0] FULL_LVL = (AW + 1)'(DEPTH);

    logic [7:0]  mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        wr_en;
    logic        rd_en;

    assign level = wr_ptr - rd_ptr;
    assign full  = (level == FULL_LVL);
    assign empty = (wr_ptr == rd_ptr);
    assign wr_en = push && !full;
    assign rd_en = pop && !empty;
    assign dout  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/uart_fifo_transmitter.sv
// UART transmitter with TX FIFO and per-frame latched format (5..8 bits, parity, 1/2 stops).
// Define UART_TX_CTS_EN to add a synchronised cts_n input that gates frame starts.
module uart_fifo_transmitter
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int DIV_WIDTH  = 24
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic                 tx,
    input  logic [1:0]           dataBits,
    input  logic                 hasParity,
    input  logic [1:0]           parityMode,
    input  logic                 extraStopBit,
    input  logic [DIV_WIDTH-1:0] clockDivisor,
    uart_fifo_transmitter_if.slave host
`ifdef UART_TX_CTS_EN
    ,
    input  logic                 cts_n
`endif
);
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

    state_t               state;
    state_t               nxt;
    logic                 pop;
    logic                 empty;
    logic                 full;
    logic                 can_start;
    logic                 bit_end;
    logic                 tx_bit;
    logic                 par_bit;
    logic                 lat_par;
    logic                 lat_stop2;
    logic                 overflow;
    logic [7:0]           dout;
    logic [7:0]           word;
    logic [7:0]           shreg;
    logic [2:0]           bit_cnt;
    logic [DIV_WIDTH-1:0] cnt;
    logic [DIV_WIDTH-1:0] lat_div;
    logic [DIV_WIDTH-1:0] div_eff;
    logic [LVL_W-1:0]     level;

    uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (host.push),
        .pop   (pop),
        .din   (host.data),
        .dout  (dout),
        .full  (full),
        .empty (empty),
        .level (level)
    );

`ifdef UART_TX_CTS_EN
    logic [1:0] cts_sync;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cts_sync <= 2'b11;
        else      cts_sync <= {cts_sync[0], cts_n};
    end

    assign can_start = !empty && !cts_sync[1];
`else
    assign can_start = !empty;
`endif

    assign host.full     = full;
    assign host.level    = level;
    assign host.overflow = overflow;
    assign host.ready    = empty && (state == S_IDLE);

    assign div_eff = (clockDivisor == '0) ? DIV_WIDTH'(1) : clockDivisor;
    assign word    = dout & data_mask(dataBits);
    assign bit_end = (cnt == DIV_WIDTH'(1));

    always_comb begin
        nxt = state;
        pop = 1'b0;
        unique case (state)
            S_IDLE: if (can_start) begin
                pop = 1'b1;
                nxt = S_START;
            end
            S_START: if (bit_end) nxt = S_DATA;
            S_DATA: if (bit_end && bit_cnt == 3'd0)
                nxt = lat_par ? S_PARITY : S_STOP;
            S_PARITY: if (bit_end) nxt = S_STOP;
            S_STOP: if (bit_end) begin
                if (lat_stop2) begin
                    nxt = S_STOP2;
                end else if (can_start) begin
                    pop = 1'b1;
                    nxt = S_START;
                end else begin
                    nxt = S_IDLE;
                end
            end
            S_STOP2: if (bit_end) begin
                if (can_start) begin
                    pop = 1'b1;
                    nxt = S_START;
                end else begin
                    nxt = S_IDLE;
                end
            end
            default: nxt = S_IDLE;
        endcase
    end

    always_comb begin
        tx_bit = 1'b1;
        unique case (state)
            S_START:  tx_bit = 1'b0;
            S_DATA:   tx_bit = shreg[0];
            S_PARITY: tx_bit = par_bit;
            default:  tx_bit = 1'b1;
        endcase
    end

    // tx is registered from the current state, so the pin lags the FSM by one cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            tx        <= 1'b1;
            overflow  <= 1'b0;
            cnt       <= '0;
            lat_div   <= '0;
            shreg     <= '0;
            bit_cnt   <= '0;
            par_bit   <= 1'b0;
            lat_par   <= 1'b0;
            lat_stop2 <= 1'b0;
        end else begin
            state    <= nxt;
            tx       <= tx_bit;
            overflow <= host.push && full;
            if (pop) begin
                cnt       <= div_eff;
                lat_div   <= div_eff;
                shreg     <= word;
                bit_cnt   <= 3'(dataBits) + 3'd4;
                par_bit   <= parity_bit(parityMode, word);
                lat_par   <= hasParity;
                lat_stop2 <= extraStopBit;
            end else if (state != S_IDLE) begin
                if (bit_end) begin
                    cnt <= lat_div;
                    if (state == S_DATA) begin
                        shreg   <= shreg >> 1;
                        bit_cnt <= bit_cnt - 3'd1;
                    end
                end else begin
                    cnt <= cnt - DIV_WIDTH'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_fifo_transmitter.sv
// Scoreboard bench for uart_fifo_transmitter: frames queued at push, checked by a tx monitor.
// Define UART_TX_CTS_EN to also exercise the clear-to-send path.
module tb_uart_fifo_transmitter;

    typedef struct {
        logic [255:0] bits;
        int           len;
    } frame_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        tx;
    logic [1:0]  data_bits;
    logic        has_par;
    logic [1:0]  par_mode;
    logic        stop2;
    logic [23:0] divisor;
`ifdef UART_TX_CTS_EN
    logic        cts_n;
`endif

    frame_t exp_q[$];
    int     gap_q[$];
    int     checks = 0;
    int     errors = 0;
    int     cyc = 0;
    int     last_end = 0;
    int     frames_done = 0;
    bit     busy = 1'b0;
    int     n_before;

    uart_fifo_transmitter_if #(.LVL_W(3)) host ();

    uart_fifo_transmitter #(
        .FIFO_DEPTH (4),
        .DIV_WIDTH  (24)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .tx           (tx),
        .dataBits     (data_bits),
        .hasParity    (has_par),
        .parityMode   (par_mode),
        .extraStopBit (stop2),
        .clockDivisor (divisor),
        .host         (host)
`ifdef UART_TX_CTS_EN
        ,
        .cts_n        (cts_n)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected tx waveform, one entry per clk, for the current format settings
    function automatic frame_t build(input logic [7:0] d);
        frame_t f;
        bit     q[$];
        int     n;
        int     dv;
        int     ones;
        n    = int'(data_bits) + 5;
        dv   = (divisor == 0) ? 1 : int'(divisor);
        ones = 0;
        f.bits = '0;
        f.len  = 0;
        q.push_back(1'b0);
        for (int i = 0; i < n; i++) begin
            q.push_back(d[i]);
            ones += int'(d[i]);
        end
        if (has_par) begin
            case (par_mode)
                2'b00: q.push_back(1'b0);
                2'b11: q.push_back(1'b1);
                2'b01: q.push_back(ones % 2 == 1);
                default: q.push_back(ones % 2 == 0);
            endcase
        end
        q.push_back(1'b1);
        if (stop2) q.push_back(1'b1);
        foreach (q[k]) begin
            for (int r = 0; r < dv; r++) begin
                f.bits[f.len] = q[k];
                f.len++;
            end
        end
        return f;
    endfunction

    task automatic push_word(input logic [7:0] d);
        @(negedge clk);
        host.data = d;
        host.push = 1'b1;
        exp_q.push_back(build(d));
        @(negedge clk);
        host.push = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int limit);
        bit done;
        done = 1'b0;
        for (int i = 0; i < limit; i++) begin
            if (exp_q.size() == 0 && !busy) begin
                done = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk(name, 32'(done), 32'd1);
    endtask

    task automatic wait_frames(input string name, input int target, input int limit);
        bit done;
        done = 1'b0;
        for (int i = 0; i < limit; i++) begin
            if (frames_done >= target && !busy) begin
                done = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk(name, 32'(done), 32'd1);
    endtask

    // Monitor: a falling tx while idle starts a frame, which is captured and compared
    initial begin : monitor
        frame_t       f;
        logic [255:0] act;
        bit           aborted;
        forever begin
            @(negedge clk);
            if (rst === 1'b1 && tx === 1'b0) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_frame: got start bit at cycle %0d expected none", cyc);
                    for (int i = 0; i < 300 && tx === 1'b0; i++) @(negedge clk);
                end else begin
                    f = exp_q.pop_front();
                    busy = 1'b1;
                    gap_q.push_back(cyc - last_end - 1);
                    act = '0;
                    aborted = 1'b0;
                    for (int i = 1; i < f.len; i++) begin
                        @(negedge clk);
                        if (rst !== 1'b1) begin
                            aborted = 1'b1;
                            break;
                        end
                        act[i] = tx;
                    end
                    busy = 1'b0;
                    if (!aborted) begin
                        checks++;
                        if (act !== f.bits) begin
                            errors++;
                            $display("FAIL frame: got %h expected %h", act, f.bits);
                        end
                        last_end = cyc;
                        frames_done++;
                    end
                end
            end
        end
    end

    initial begin : stim
        logic [7:0] w [6];
        w = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        rst       = 1'b0;
        host.push = 1'b0;
        host.data = 8'h00;
        data_bits = 2'd3;
        has_par   = 1'b0;
        par_mode  = 2'b00;
        stop2     = 1'b0;
        divisor   = 24'd10;
`ifdef UART_TX_CTS_EN
        cts_n     = 1'b0;
`endif
        repeat (3) @(negedge clk);
        chk("rst_tx", 32'(tx), 32'd1);
        chk("rst_full", 32'(host.full), 32'd0);
        chk("rst_level", 32'(host.level), 32'd0);
        chk("rst_overflow", 32'(host.overflow), 32'd0);
        chk("rst_ready", 32'(host.ready), 32'd1);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // 8N1, divisor 10, 0x60 with push-to-start latency
        push_word(8'h60);
        chk("t1_level", 32'(host.level), 32'd1);
        chk("t1_ready_busy", 32'(host.ready), 32'd0);
        chk("t1_tx_before_pop", 32'(tx), 32'd1);
        @(negedge clk);
        chk("t1_tx_at_pop", 32'(tx), 32'd1);
        chk("t1_level_popped", 32'(host.level), 32'd0);
        @(negedge clk);
        chk("t1_tx_start", 32'(tx), 32'd0);
        wait_idle("t1_done", 500);
        chk("t1_ready", 32'(host.ready), 32'd1);
        chk("t1_tx_idle", 32'(tx), 32'd1);

        // 7 data bits, odd parity: only 0x25 of 0xA5 goes out, parity 0
        data_bits = 2'd2;
        has_par   = 1'b1;
        par_mode  = 2'b10;
        divisor   = 24'd3;
        push_word(8'hA5);
        wait_idle("t2_done", 500);

        // divisor 0 acts as 1, two stop bits, 5-bit frames with space/even/mark parity
        data_bits = 2'd0;
        par_mode  = 2'b00;
        stop2     = 1'b1;
        divisor   = 24'd0;
        push_word(8'h1F);
        wait_idle("t4_space", 200);
        par_mode = 2'b01;
        push_word(8'h0B);
        wait_idle("t4_even", 200);
        par_mode = 2'b11;
        push_word(8'h00);
        wait_idle("t4_mark", 200);

        // six pushes on consecutive edges into a depth-4 FIFO
        data_bits = 2'd3;
        has_par   = 1'b0;
        stop2     = 1'b0;
        divisor   = 24'd2;
        gap_q.delete();
        @(negedge clk);
        host.push = 1'b1;
        for (int i = 0; i < 6; i++) begin
            host.data = w[i];
            if (i < 5) exp_q.push_back(build(w[i]));
            @(negedge clk);
            if (i == 4) begin
                chk("t3_full", 32'(host.full), 32'd1);
                chk("t3_level_peak", 32'(host.level), 32'd4);
                chk("t3_no_overflow", 32'(host.overflow), 32'd0);
            end
            if (i == 5) begin
                chk("t3_overflow", 32'(host.overflow), 32'd1);
                chk("t3_level_after_drop", 32'(host.level), 32'd4);
            end
        end
        host.push = 1'b0;
        @(negedge clk);
        chk("t3_overflow_pulse", 32'(host.overflow), 32'd0);
        wait_idle("t3_done", 1000);
        chk("t3_frame_count", 32'(gap_q.size()), 32'd5);
        for (int k = 1; k < 5 && k < gap_q.size(); k++)
            chk("t3_gap", 32'(gap_q[k]), 32'd0);

        // reset while frame 2 of 3 is shifting data bits
        divisor = 24'd4;
        @(negedge clk);
        host.push = 1'b1;
        for (int i = 0; i < 3; i++) begin
            host.data = w[i];
            exp_q.push_back(build(w[i]));
            @(negedge clk);
        end
        host.push = 1'b0;
        for (int i = 0; i < 500 && exp_q.size() > 1; i++) @(negedge clk);
        chk("t5_frame2_started", 32'(exp_q.size()), 32'd1);
        repeat (12) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("t5_tx_reset", 32'(tx), 32'd1);
        chk("t5_level_reset", 32'(host.level), 32'd0);
        chk("t5_full_reset", 32'(host.full), 32'd0);
        chk("t5_ready_reset", 32'(host.ready), 32'd1);
        exp_q.delete();
        repeat (3) @(negedge clk);
        rst = 1'b1;
        n_before = frames_done;
        repeat (100) @(negedge clk);
        chk("t5_silent_tx", 32'(tx), 32'd1);
        chk("t5_silent_level", 32'(host.level), 32'd0);
        chk("t5_silent_frames", 32'(frames_done), 32'(n_before));
        push_word(8'h3C);
        wait_idle("t5_recover", 500);
        chk("t5_recover_frames", 32'(frames_done), 32'(n_before + 1));

`ifdef UART_TX_CTS_EN
        // held by cts_n=1, released 3 clk before start, dropped mid-frame
        divisor = 24'd2;
        cts_n   = 1'b1;
        repeat (4) @(negedge clk);
        push_word(8'h81);
        push_word(8'h42);
        repeat (20) @(negedge clk);
        chk("t6_tx_held", 32'(tx), 32'd1);
        chk("t6_level_held", 32'(host.level), 32'd2);
        n_before = frames_done;
        cts_n = 1'b0;
        @(negedge clk);
        chk("t6_tx_e0", 32'(tx), 32'd1);
        @(negedge clk);
        chk("t6_tx_e1", 32'(tx), 32'd1);
        @(negedge clk);
        chk("t6_tx_e2", 32'(tx), 32'd1);
        @(negedge clk);
        chk("t6_tx_start", 32'(tx), 32'd0);
        cts_n = 1'b1;
        wait_frames("t6_first_done", n_before + 1, 500);
        repeat (10) @(negedge clk);
        chk("t6_level_hold2", 32'(host.level), 32'd1);
        chk("t6_tx_hold2", 32'(tx), 32'd1);
        cts_n = 1'b0;
        wait_idle("t6_drain", 500);
        chk("t6_level_drained", 32'(host.level), 32'd0);
`endif

        repeat (5) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
